// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide, 32 iterations plus one sign-fix cycle.
module muldiv_unit (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] InA,
  input  logic [31:0] InB,
  input  logic        mthi,
  input  logic        mtlo,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] a_raw_q, a_raw_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        divz_q, divz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic        div_borrow;
  logic        div_ok;
  logic [63:0] prod_neg;

  assign a_neg   = ~op[0] & InA[31];
  assign b_neg   = ~op[0] & InB[31];
  assign a_mag   = a_neg ? (~InA + 32'd1) : InA;
  assign b_mag   = b_neg ? (~InB + 32'd1) : InB;

  assign mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
  assign div_shift = {acc_q[63:32], acc_q[31]};
  assign {div_borrow, div_diff} = {1'b0, div_shift} - {2'b00, opnd_q};
  // A successful trial subtraction always leaves a remainder below the divisor.
  assign div_ok   = ~div_borrow & ~div_diff[32];
  assign prod_neg = ~acc_q + 64'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    a_raw_d   = a_raw_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    divz_d    = divz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = CALC;
          cnt_d     = 6'd0;
          busy_d    = 1'b1;
          is_div_d  = op[1];
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          divz_d    = op[1] & (InB == 32'd0);
          a_raw_d   = InA;
          // Low half of the accumulator holds the multiplier or the dividend.
          if (op[1]) begin
            acc_d  = {32'd0, a_mag};
            opnd_d = b_mag;
          end else begin
            acc_d  = {32'd0, b_mag};
            opnd_d = a_mag;
          end
        end else begin
          if (mthi) hi_d = InA;
          if (mtlo) lo_d = InA;
        end
      end

      CALC: begin
        if (is_div_q) begin
          if (div_ok) acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
          else        acc_d = {div_shift[31:0], acc_q[30:0], 1'b0};
        end else begin
          if (acc_q[0]) acc_d = {mul_sum, acc_q[31:1]};
          else          acc_d = {1'b0, acc_q[63:1]};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = FIX;
      end

      FIX: begin
        if (!is_div_q) begin
          {hi_d, lo_d} = neg_res_q ? prod_neg : acc_q;
        end else if (divz_q) begin
          lo_d = 32'hFFFF_FFFF;
          hi_d = a_raw_q;
        end else begin
          lo_d = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
          hi_d = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      acc_q     <= 64'd0;
      opnd_q    <= 32'd0;
      a_raw_q   <= 32'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divz_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      a_raw_q   <= a_raw_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      divz_q    <= divz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign Hi   = hi_q;
  assign Lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: arithmetic results, timing, ignored inputs, reset abort.
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] InA;
  logic [31:0] InB;
  logic        mthi;
  logic        mtlo;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  muldiv_unit dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .InA     (InA),
    .InB     (InB),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .Hi      (Hi),
    .Lo      (Lo),
    .busy    (busy),
    .done    (done)
  );

  always #5 clock = ~clock;

  // Called at a falling edge; returns at the falling edge where done is seen.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int bcnt, output logic got_done);
    op = o; InA = a; InB = b; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    bcnt = 0;
    got_done = 1'b0;
    for (int i = 0; i < 40 && !got_done; i++) begin
      @(negedge clock);
      if (busy) bcnt++;
      if (done) got_done = 1'b1;
    end
  endtask

  task automatic test_reset;
    checks++; if (Hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected %h", Hi, 32'd0); end
    checks++; if (Lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected %h", Lo, 32'd0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    $display("reset: Hi=%h Lo=%h busy=%b done=%b", Hi, Lo, busy, done);
  endtask

  task automatic test_multu;
    int bcnt; logic gd;
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bcnt, gd);
    checks++; if (gd !== 1'b1) begin errors++; $display("FAIL multu_timeout: got done=%b expected 1", gd); end
    checks++; if (Hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h expected %h", Hi, 32'hFFFF_FFFE); end
    checks++; if (Lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h expected %h", Lo, 32'h1); end
    checks++; if (bcnt != 33) begin errors++; $display("FAIL multu_busy_len: got %0d expected 33", bcnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_drop: got %b expected 0", busy); end
    $display("MULTU ffffffff*ffffffff: Hi=%h Lo=%h busy_cycles=%0d", Hi, Lo, bcnt);
    @(negedge clock);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_width: got %b expected 0", done); end
  endtask

  task automatic test_mult;
    int bcnt; logic gd;
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, bcnt, gd);
    checks++; if (gd !== 1'b1) begin errors++; $display("FAIL mult_timeout: got done=%b expected 1", gd); end
    checks++; if (Hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h expected %h", Hi, 32'hFFFF_FFFF); end
    checks++; if (Lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_lo: got %h expected %h", Lo, 32'hFFFF_FFF1); end
    $display("MULT -3*5: Hi=%h Lo=%h", Hi, Lo);
    @(negedge clock);
  endtask

  task automatic test_div;
    int bcnt; logic gd;
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, bcnt, gd);
    checks++; if (gd !== 1'b1) begin errors++; $display("FAIL div_timeout: got done=%b expected 1", gd); end
    checks++; if (Lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h expected %h", Lo, 32'hFFFF_FFFD); end
    checks++; if (Hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h expected %h", Hi, 32'hFFFF_FFFF); end
    checks++; if (bcnt != 33) begin errors++; $display("FAIL div_busy_len: got %0d expected 33", bcnt); end
    $display("DIV -7/2: Hi=%h Lo=%h", Hi, Lo);
    @(negedge clock);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, bcnt, gd);
    checks++; if (gd !== 1'b1) begin errors++; $display("FAIL divovf_timeout: got done=%b expected 1", gd); end
    checks++; if (Lo !== 32'h8000_0000) begin errors++; $display("FAIL divovf_lo: got %h expected %h", Lo, 32'h8000_0000); end
    checks++; if (Hi !== 32'd0) begin errors++; $display("FAIL divovf_hi: got %h expected %h", Hi, 32'd0); end
    $display("DIV 80000000/ffffffff: Hi=%h Lo=%h", Hi, Lo);
    @(negedge clock);
    run_op(2'b11, 32'd100, 32'd7, bcnt, gd);
    checks++; if (Lo !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h expected %h", Lo, 32'd14); end
    checks++; if (Hi !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h expected %h", Hi, 32'd2); end
    $display("DIVU 100/7: Hi=%h Lo=%h", Hi, Lo);
    @(negedge clock);
  endtask

  task automatic test_div_zero;
    int bcnt; logic gd;
    run_op(2'b11, 32'd7, 32'd0, bcnt, gd);
    checks++; if (gd !== 1'b1) begin errors++; $display("FAIL divz_timeout: got done=%b expected 1", gd); end
    checks++; if (Lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_lo: got %h expected %h", Lo, 32'hFFFF_FFFF); end
    checks++; if (Hi !== 32'd7) begin errors++; $display("FAIL divz_hi: got %h expected %h", Hi, 32'd7); end
    checks++; if (bcnt != 33) begin errors++; $display("FAIL divz_busy_len: got %0d expected 33", bcnt); end
    $display("DIVU 7/0: Hi=%h Lo=%h", Hi, Lo);
    @(negedge clock);
    run_op(2'b10, 32'hFFFF_FFF0, 32'd0, bcnt, gd);
    checks++; if (Lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_s_lo: got %h expected %h", Lo, 32'hFFFF_FFFF); end
    checks++; if (Hi !== 32'hFFFF_FFF0) begin errors++; $display("FAIL divz_s_hi: got %h expected %h", Hi, 32'hFFFF_FFF0); end
    $display("DIV -16/0: Hi=%h Lo=%h", Hi, Lo);
    @(negedge clock);
  endtask

  task automatic test_busy_inputs;
    int bcnt; logic gd;
    op = 2'b01; InA = 32'h0001_0000; InB = 32'h30; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    bcnt = 0; gd = 1'b0;
    for (int i = 0; i < 40 && !gd; i++) begin
      @(negedge clock);
      if (busy) bcnt++;
      if (done) gd = 1'b1;
      if (i == 9) begin
        start = 1'b1; mthi = 1'b1; op = 2'b00; InA = 32'hDEAD_0000; InB = 32'd5;
      end else if (i == 10) begin
        start = 1'b0; mthi = 1'b0;
      end
    end
    checks++; if (gd !== 1'b1) begin errors++; $display("FAIL busyin_timeout: got done=%b expected 1", gd); end
    checks++; if (Lo !== 32'h0030_0000) begin errors++; $display("FAIL busyin_lo: got %h expected %h", Lo, 32'h0030_0000); end
    checks++; if (Hi !== 32'd0) begin errors++; $display("FAIL busyin_hi: got %h expected %h", Hi, 32'd0); end
    checks++; if (bcnt != 33) begin errors++; $display("FAIL busyin_busy_len: got %0d expected 33", bcnt); end
    $display("MULTU with ignored start/mthi: Hi=%h Lo=%h busy_cycles=%0d", Hi, Lo, bcnt);
    @(negedge clock);
    InA = 32'h1234; mtlo = 1'b1;
    @(posedge clock);
    #1 mtlo = 1'b0;
    @(negedge clock);
    checks++; if (Lo !== 32'h1234) begin errors++; $display("FAIL mtlo_lo: got %h expected %h", Lo, 32'h1234); end
    checks++; if (Hi !== 32'd0) begin errors++; $display("FAIL mtlo_hi: got %h expected %h", Hi, 32'd0); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mtlo_done: got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy: got %b expected 0", busy); end
    $display("MTLO 1234: Hi=%h Lo=%h done=%b", Hi, Lo, done);
    InA = 32'hABCD; mthi = 1'b1; mtlo = 1'b1;
    @(posedge clock);
    #1 mthi = 1'b0; mtlo = 1'b0;
    @(negedge clock);
    checks++; if (Hi !== 32'hABCD) begin errors++; $display("FAIL mthilo_hi: got %h expected %h", Hi, 32'hABCD); end
    checks++; if (Lo !== 32'hABCD) begin errors++; $display("FAIL mthilo_lo: got %h expected %h", Lo, 32'hABCD); end
    $display("MTHI+MTLO abcd: Hi=%h Lo=%h", Hi, Lo);
  endtask

  task automatic test_reset_mid;
    int bcnt; logic gd; logic saw_done;
    op = 2'b10; InA = 32'd100; InB = 32'd7; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (14) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (Hi !== 32'd0) begin errors++; $display("FAIL rstmid_hi: got %h expected %h", Hi, 32'd0); end
    checks++; if (Lo !== 32'd0) begin errors++; $display("FAIL rstmid_lo: got %h expected %h", Lo, 32'd0); end
    $display("reset mid-DIV: Hi=%h Lo=%h busy=%b", Hi, Lo, busy);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rstmid_no_done: got %b expected 0", saw_done); end
    run_op(2'b01, 32'd6, 32'd7, bcnt, gd);
    checks++; if (gd !== 1'b1) begin errors++; $display("FAIL rstmid_mul_timeout: got done=%b expected 1", gd); end
    checks++; if (Lo !== 32'd42) begin errors++; $display("FAIL rstmid_mul_lo: got %h expected %h", Lo, 32'd42); end
    checks++; if (Hi !== 32'd0) begin errors++; $display("FAIL rstmid_mul_hi: got %h expected %h", Hi, 32'd0); end
    $display("MULTU 6*7 after reset: Hi=%h Lo=%h", Hi, Lo);
  endtask

  // Entered at the falling edge where done is high: the next start is accepted at E34.
  task automatic test_back_to_back;
    int bcnt; logic gd;
    run_op(2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFD, bcnt, gd);
    checks++; if (gd !== 1'b1) begin errors++; $display("FAIL b2b_timeout: got done=%b expected 1", gd); end
    checks++; if (bcnt != 33) begin errors++; $display("FAIL b2b_busy_len: got %0d expected 33", bcnt); end
    checks++; if (Lo !== 32'd6) begin errors++; $display("FAIL b2b_lo: got %h expected %h", Lo, 32'd6); end
    checks++; if (Hi !== 32'd0) begin errors++; $display("FAIL b2b_hi: got %h expected %h", Hi, 32'd0); end
    $display("back-to-back MULT -2*-3: Hi=%h Lo=%h busy_cycles=%0d", Hi, Lo, bcnt);
    @(negedge clock);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; op = 2'b00; InA = 32'd0; InB = 32'd0; mthi = 1'b0; mtlo = 1'b0;
    repeat (2) @(negedge clock);
    test_reset;
    reset_n = 1'b1;
    @(negedge clock);
    test_multu;
    test_mult;
    test_div;
    test_div_zero;
    test_busy_inputs;
    @(negedge clock);
    test_reset_mid;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
